// File: rtl/fft16_pkg.sv
// fft16_pkg: shared constants, the sequencer state type and the
// bit-reverse helper for the 16-point FFT frame sequencer.
package fft16_pkg;

  localparam int NPTS   = 16;
  localparam int NSTAGE = 4;
  localparam int AW     = $clog2(NPTS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    GO     = 3'd2,
    WAIT   = 3'd3,
    UNLOAD = 3'd4
  } seq_state_t;

  // Mirror an AW-bit index so bit 0 becomes bit AW-1.
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft16_bitrev_addr.sv
// fft16_bitrev_addr: combinational natural-order count to bit-reversed
// address mapping, reusable by any output-reorder logic.
module fft16_bitrev_addr #(
  parameter int AW = 4
) (
  input  logic [AW-1:0] count,
  output logic [AW-1:0] addr
);

  // Pure wiring: output bit gi comes from input bit AW-1-gi.
  for (genvar gi = 0; gi < AW; gi++) begin : g_rev
    assign addr[gi] = count[AW-1-gi];
  end

endmodule

// File: rtl/fft16_frame_sequencer.sv
// fft16_frame_sequencer: loads one 16-sample frame, steps the radix-2
// stages one start pulse at a time, then unloads in bit-reversed order.
// Optional stage watchdog enabled by defining FFT_SEQ_STAGE_TIMEOUT_EN;
// without it err is tied low and WAIT may wait forever.
module fft16_frame_sequencer #(
  parameter int NPTS   = fft16_pkg::NPTS,
  parameter int NSTAGE = fft16_pkg::NSTAGE
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      load_we,
  output logic [$clog2(NPTS)-1:0]   load_addr,
  output logic                      stage_go,
  output logic [$clog2(NSTAGE)-1:0] stage_idx,
  input  logic                      stage_done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NPTS)-1:0]   out_addr,
  output logic                      out_last,
  output logic                      busy,
  output logic                      err
);

  import fft16_pkg::*;

  localparam int ADDR_W = $clog2(NPTS);
  localparam int IDX_W  = $clog2(NSTAGE);
  localparam logic [ADDR_W-1:0] LAST_CNT   = ADDR_W'(NPTS - 1);
  localparam logic [IDX_W-1:0]  LAST_STAGE = IDX_W'(NSTAGE - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [IDX_W-1:0]  stage_idx_q, stage_idx_d;
  logic              stage_go_q, stage_go_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] rev_addr;

`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT - 1);
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
`endif

  // The registered out_addr must show the address for the count the FSM
  // is moving to, so reverse the next-state count.
  fft16_bitrev_addr #(
    .AW (ADDR_W)
  ) u_bitrev (
    .count (count_d),
    .addr  (rev_addr)
  );

  // Next-state and next-output computation for the frame sequencer.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    stage_idx_d = stage_idx_q;
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
    timer_d     = timer_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        // First accept writes address 0 with no bubble.
        if (in_valid) begin
          count_d = ADDR_W'(1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (count_q == LAST_CNT) begin
            count_d = '0;
            state_d = GO;
          end else begin
            count_d = count_q + ADDR_W'(1);
          end
        end
      end
      GO: begin
        state_d = WAIT;
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
        timer_d = '0;
`endif
      end
      WAIT: begin
        if (stage_done) begin
          if (stage_idx_q == LAST_STAGE) begin
            stage_idx_d = '0;
            state_d     = UNLOAD;
          end else begin
            stage_idx_d = stage_idx_q + IDX_W'(1);
            state_d     = GO;
          end
        end
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
        else if (timer_q == LAST_TICK) begin
          // Datapath never answered: flag it and drop the frame.
          err_d       = 1'b1;
          state_d     = IDLE;
          count_d     = '0;
          stage_idx_d = '0;
          timer_d     = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      UNLOAD: begin
        if (out_valid_q && out_ready) begin
          if (count_q == LAST_CNT) begin
            count_d = '0;
            state_d = IDLE;
          end else begin
            count_d = count_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        count_d     = '0;
        stage_idx_d = '0;
      end
    endcase

    // Outputs are registered against the state being entered so they line
    // up with state_q on the following cycle.
    stage_go_d  = (state_d == GO);
    out_valid_d = (state_d == UNLOAD);
    out_addr_d  = out_valid_d ? rev_addr : '0;
    out_last_d  = out_valid_d && (count_d == LAST_CNT);
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      stage_idx_q <= '0;
      stage_go_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
      timer_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      stage_idx_q <= stage_idx_d;
      stage_go_q  <= stage_go_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
      timer_q     <= timer_d;
      err_q       <= err_d;
`endif
    end
  end

  // in_ready is held low while reset is asserted so nothing is accepted
  // into a frame that is about to be discarded.
  assign in_ready  = ~rst & ((state_q == IDLE) | (state_q == LOAD));
  assign load_we   = in_valid & in_ready;
  assign load_addr = count_q;
  assign stage_go  = stage_go_q;
  assign stage_idx = stage_idx_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fft16_frame_sequencer.sv
// tb_fft16_frame_sequencer: randomized stimulus against a frame-level
// scoreboard (samples loaded, stages finished, outputs handed off).
module tb_fft16_frame_sequencer;

  localparam int NPTS    = 16;
  localparam int NSTAGE  = 4;
  localparam int TIMEOUT = 64;
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       load_we;
  logic [3:0] load_addr;
  logic       stage_go;
  logic [1:0] stage_idx;
  logic       stage_done;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_addr;
  logic       out_last;
  logic       busy;
  logic       err;

  fft16_frame_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load_we    (load_we),
    .load_addr  (load_addr),
    .stage_go   (stage_go),
    .stage_idx  (stage_idx),
    .stage_done (stage_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboard state
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_loaded, n_stages, n_out, wait_cnt, done_due;
  int obs_go, obs_last, pat_idx, frames_done;
  bit go_due, err_exp;

  // Stimulus policy
  int p_valid, ready_mode, dly_min, dly_max;
  bit valid_in_wait, withhold, spurious;
  bit pat [4];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Bit reversal by repeated doubling, independent of any bit slicing.
  function automatic int rev4(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  task automatic reset_model();
    n_loaded = 0; n_stages = 0; n_out = 0; wait_cnt = 0; done_due = 0;
    obs_go = 0; obs_last = 0; pat_idx = 0; go_due = 0; err_exp = 0;
  endtask

  task automatic drop_frame();
    n_loaded = 0; n_stages = 0; n_out = 0; obs_go = 0; obs_last = 0; pat_idx = 0;
  endtask

  // One clock cycle: drive inputs, check outputs, advance the scoreboard.
  task automatic step(input bit drv_rst);
    bit waiting, exp_ov, exp_ready, drv_valid, drv_ready, drv_done, nxt_go;
    @(negedge clk);
    cyc++;
    waiting = (n_loaded == NPTS) && (n_stages < NSTAGE) && !go_due;
    exp_ov  = (n_stages == NSTAGE);
    if (go_due) done_due = cyc + int'($urandom_range(dly_max, dly_min));

    if (n_loaded < NPTS) drv_valid = ($urandom_range(99) < p_valid);
    else drv_valid = valid_in_wait ? 1'b1 : 1'($urandom_range(1));
    case (ready_mode)
      0:       drv_ready = 1'b1;
      1:       drv_ready = pat[pat_idx % 4];
      default: drv_ready = 1'($urandom_range(1));
    endcase
    if (exp_ov) pat_idx++;
    drv_done = waiting && !withhold && (cyc >= done_due);
    if (!waiting && spurious && ($urandom_range(7) == 0)) drv_done = 1'b1;

    rst = drv_rst; in_valid = drv_valid; out_ready = drv_ready; stage_done = drv_done;
    #1;

    exp_ready = !drv_rst && (n_loaded < NPTS);
    check_eq("in_ready", int'(in_ready), int'(exp_ready));
    check_eq("load_we", int'(load_we), int'(exp_ready && drv_valid));
    if (n_loaded < NPTS) check_eq("load_addr", int'(load_addr), n_loaded);
    check_eq("stage_go", int'(stage_go), int'(go_due));
    check_eq("stage_idx", int'(stage_idx), (go_due || waiting) ? n_stages : 0);
    check_eq("out_valid", int'(out_valid), int'(exp_ov));
    if (exp_ov) check_eq("out_addr", int'(out_addr), rev4(n_out));
    check_eq("out_last", int'(out_last), int'(exp_ov && (n_out == NPTS - 1)));
    check_eq("busy", int'(busy), int'(n_loaded != 0));
    check_eq("err", int'(err), int'(err_exp));
    obs_go += int'(stage_go);
    if (out_valid && drv_ready && out_last) obs_last++;

    nxt_go = 1'b0;
    if (drv_rst) begin
      reset_model();
    end else begin
      if (go_due) wait_cnt = 0;
      if (exp_ready && drv_valid) begin
        n_loaded++;
        if (n_loaded == NPTS) nxt_go = 1'b1;
      end
      if (waiting) begin
        if (drv_done) begin
          n_stages++;
          if (n_stages < NSTAGE) nxt_go = 1'b1;
        end else begin
          wait_cnt++;
          if (TIMEOUT_EN && wait_cnt == TIMEOUT) begin
            err_exp = 1'b1;
            drop_frame();
            $display("frame aborted by stage timeout at cycle %0d", cyc);
          end
        end
      end
      if (exp_ov && drv_ready) begin
        n_out++;
        if (n_out == NPTS) begin
          check_eq("frame_stage_go_count", obs_go, NSTAGE);
          check_eq("frame_last_count", obs_last, 1);
          frames_done++;
          $display("frame %0d complete at cycle %0d", frames_done, cyc);
          drop_frame();
        end
      end
      go_due = nxt_go;
    end
  endtask

  task automatic run_frames(input int n);
    int target;
    int guard;
    target = frames_done + n;
    guard  = 0;
    while (frames_done < target && guard < 4000) begin
      step(1'b0);
      guard++;
    end
    check_eq("frames_completed", frames_done, target);
  endtask

  initial begin
    int guard;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stage_done = 1'b0;
    frames_done = 0;
    reset_model();
    p_valid = 100; valid_in_wait = 1'b0; ready_mode = 0;
    dly_min = 3; dly_max = 3; withhold = 1'b0; spurious = 1'b0;

    repeat (3) step(1'b1);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_out_addr", int'(out_addr), 0);
    check_eq("reset_stage_idx", int'(stage_idx), 0);

    // Back-to-back load, 3-cycle stages, always-ready unload
    run_frames(1);

    // Output stall pattern 1,0,0,1
    ready_mode = 1;
    run_frames(1);

    // Input gaps, in_valid held high while busy, random stage latency
    p_valid = 60; valid_in_wait = 1'b1; ready_mode = 2;
    dly_min = 1; dly_max = 6; spurious = 1'b1;
    run_frames(1);

    // Reset in the middle of WAIT at stage 2
    p_valid = 100; ready_mode = 0; dly_min = 4; dly_max = 4; spurious = 1'b0;
    guard = 0;
    while (!((n_loaded == NPTS) && !go_due && (n_stages == 2)) && guard < 500) begin
      step(1'b0);
      guard++;
    end
    check_eq("reach_wait_stage2", int'(guard < 500), 1);
    check_eq("wait_stage2_idx", int'(stage_idx), 2);
    step(1'b1);
    step(1'b0);
    check_eq("post_rst_stage_idx", int'(stage_idx), 0);
    run_frames(1);

    // Randomized frames
    p_valid = 70; ready_mode = 2; dly_min = 1; dly_max = 8; spurious = 1'b1;
    run_frames(4);

    // Withheld stage_done
    spurious = 1'b0; withhold = 1'b1; p_valid = 100;
`ifdef FFT_SEQ_STAGE_TIMEOUT_EN
    guard = 0;
    while (!err_exp && guard < 400) begin
      step(1'b0);
      guard++;
    end
    check_eq("timeout_reached", int'(err_exp), 1);
    p_valid = 0;
    repeat (10) step(1'b0);
    check_eq("timeout_err_sticky", int'(err), 1);
    check_eq("timeout_idle", int'(busy), 0);
    withhold = 1'b0; p_valid = 100;
    run_frames(1);
    check_eq("err_held_after_frame", int'(err), 1);
    step(1'b1);
    step(1'b0);
    check_eq("err_cleared_by_rst", int'(err), 0);
`else
    repeat (150) step(1'b0);
    check_eq("no_timeout_busy", int'(busy), 1);
    check_eq("no_timeout_err", int'(err), 0);
    withhold = 1'b0;
    run_frames(1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft16_frame_sequencer.md
Name: fft16_frame_sequencer

Overview:
- Control sequencer for the 16-point FFT datapath: loads one 16-sample complex frame, steps the butterfly stages, then unloads results.
- Sits between the serial sample stream and the parallel stage buffers and butterflies.
- Generates write strobes and addresses for the input buffer, one start pulse per stage, and bit-reversed read addresses for output.
- Addresses and control only; complex data travel on the datapath.

Parameters:
- NPTS, 16, points per frame (power of 2; log2 gives the address width AW=4).
- NSTAGE, 4, radix-2 stages per frame (= log2 NPTS).
- TIMEOUT, 64, maximum cycles to wait for stage_done (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream sample present.
- in_ready  out  1  sequencer accepts a sample this cycle.
- load_we  out  1  write strobe to input buffer = in_valid & in_ready.
- load_addr  out  AW  natural-order write index 0..15.
- stage_go  out  1  one-cycle pulse that starts a stage.
- stage_idx  out  2  stage being computed (0..NSTAGE-1), held until done.
- stage_done  in  1  one-cycle pulse from the datapath when the stage result is registered.
- out_valid  out  1  result address valid.
- out_ready  in  1  downstream accepts.
- out_addr  out  AW  bit-reversed read index.
- out_last  out  1  high with the 16th output.
- busy  out  1  high in any state except IDLE.
- err  out  1  sticky timeout flag (optional feature; tied 0 otherwise).

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, all counters 0, in_ready=0, load_we=0, stage_go=0, stage_idx=0, out_valid=0, out_addr=0, out_last=0, busy=0, err=0.
- rst in any state aborts the current frame and returns to IDLE. The aborted frame is lost.
- FSM states: IDLE, LOAD, GO, WAIT, UNLOAD.
- IDLE: in_ready=1.
  - A sample accepted here writes address 0 and moves to LOAD with load count=1.
  - An accept in IDLE is legal and costs no bubble.
- LOAD: in_ready=1; each accept writes load_addr=count, then count++.
  - When the accept at count=15 happens, go to GO next cycle; count wraps to 0.
  - in_valid low simply stalls; there is no timeout on input.
- GO: stage_go=1 for exactly one cycle with the current stage_idx; go to WAIT.
- WAIT: in_ready=0.
  - On stage_done: if stage_idx < NSTAGE-1, increment stage_idx and go to GO.
  - Otherwise reset stage_idx to 0 and go to UNLOAD.
  - stage_done seen in any other state is ignored.
- UNLOAD: out_valid=1; out_addr=bitrev(count).
  - Sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - Advance only when out_valid & out_ready. out_addr is held stable while stalled.
  - out_last=1 when count=15. Its handshake returns the FSM to IDLE; count=0.
- Latency: the last input accept sits in LOAD at count=15.
  - First stage_go comes 1 cycle after that accept.
  - Each stage costs 1 GO cycle plus the WAIT cycles.
  - First out_valid comes the cycle after the final stage_done.
- No overlap: a new frame is accepted only once the FSM is back in IDLE. in_ready stays 0 through GO, WAIT and UNLOAD.
- busy is combinational from state.

Optional Feature:
- Macro FFT_SEQ_STAGE_TIMEOUT_EN.
- Defined:
  - A cycle counter clears in GO and increments in WAIT.
  - If it reaches TIMEOUT without stage_done: set err=1 (sticky until rst), abort to IDLE and clear the counters.
- Undefined: no counter; err is tied 0; WAIT may wait forever.

Decomposition:
- Shared package fft16_pkg holds:
  - NPTS, NSTAGE and AW constants;
  - the state enum (IDLE, LOAD, GO, WAIT, UNLOAD);
  - a bitrev function for AW bits.
- One natural sub-module: fft16_bitrev_addr, a combinational count-to-reversed-address mapping that the output-reorder logic can reuse.

Test Plan:
- Reset, then 16 back-to-back in_valid samples -> load_addr 0..15 with load_we each cycle; stage_go on the cycle after the 16th accept with stage_idx=0.
- stage_done returned 3 cycles after each stage_go -> exactly 4 stage_go pulses with stage_idx 0,1,2,3; then out_valid with out_addr sequence 0,8,4,12,...,7,15 and out_last only on 15; busy falls after it.
- out_ready toggled 1,0,0,1 during UNLOAD -> out_addr held while stalled; no skipped or duplicated addresses; total 16 handshakes.
- in_valid gaps while loading, plus in_valid=1 during WAIT -> in_ready=0 in WAIT, no load_we; the next frame starts at address 0 only after return to IDLE.
- rst asserted mid-WAIT at stage_idx=2 -> next cycle: state IDLE, stage_idx=0, busy=0, in_ready=1; a fresh frame completes normally.
- With FFT_SEQ_STAGE_TIMEOUT_EN and TIMEOUT=64, withhold stage_done -> err=1 after 64 WAIT cycles, FSM in IDLE; err stays 1 until rst.
